// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalize, round-to-nearest-even and pack for the fp32 multiplier.
module fp_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_prod,
  input  logic        in_zero,
  input  logic        in_inf,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);
  logic        s1_valid, s1_sign, s1_guard, s1_sticky, s1_zero, s1_inf, s1_nan;
  logic [9:0]  s1_exp;
  logic [22:0] s1_mant;
  logic        s1_accept, s2_accept;
  logic [22:0] n_mant;
  logic        n_guard, n_sticky;
  logic [9:0]  n_exp;
  logic        round_up, special, ovf, unf, r_inx;
  logic [23:0] m2;
  logic [9:0]  e2;
  logic [31:0] r_result;
  assign s2_accept = !out_valid | out_ready;
  assign s1_accept = !s1_valid | s2_accept;
  assign in_ready  = s1_accept;
  always_comb begin
    n_mant   = in_prod[47] ? in_prod[46:24] : in_prod[45:23];
    n_guard  = in_prod[47] ? in_prod[23] : in_prod[22];
    n_sticky = in_prod[47] ? |in_prod[22:0] : |in_prod[21:0];
    n_exp    = in_exp + {9'd0, in_prod[47]};
  end
  // m2[23] is the rounding carry; m2[22:0] is already zero when it fires
  always_comb begin
    round_up = s1_guard & (s1_sticky | s1_mant[0]);
    m2       = {1'b0, s1_mant} + {23'd0, round_up};
    e2       = s1_exp + {9'd0, m2[23]};
    special  = s1_nan | s1_inf | s1_zero;
    ovf      = !special & ($signed(e2) >= $signed(10'd255));
    unf      = !special & !ovf & ($signed(e2) <= $signed(10'd0));
    r_inx    = ovf | unf | (!special & (s1_guard | s1_sticky));
    r_result = (s1_nan | (s1_inf & s1_zero)) ? 32'h7FC00000 :
               (s1_inf | ovf)                ? {s1_sign, 8'hFF, 23'd0} :
               (s1_zero | unf)               ? {s1_sign, 31'd0} :
                                               {s1_sign, e2[7:0], m2[22:0]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_exp        <= 10'd0;
      s1_mant       <= 23'd0;
      s1_guard      <= 1'b0;
      s1_sticky     <= 1'b0;
      s1_zero       <= 1'b0;
      s1_inf        <= 1'b0;
      s1_nan        <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      if (s1_accept) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign   <= in_sign;
          s1_exp    <= n_exp;
          s1_mant   <= n_mant;
          s1_guard  <= n_guard;
          s1_sticky <= n_sticky;
          s1_zero   <= in_zero;
          s1_inf    <= in_inf;
          s1_nan    <= in_nan;
        end
      end
      if (s2_accept) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result    <= r_result;
          out_overflow  <= ovf;
          out_underflow <= unf;
          out_inexact   <= r_inx;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed table, backpressure, reset and random scoreboard checks for fp_norm_round.
module tb_fp_norm_round;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, in_sign = 1'b0, in_zero = 1'b0, in_inf = 1'b0, in_nan = 1'b0;
  logic [9:0]  in_exp = 10'd0;
  logic [47:0] in_prod = 48'd0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_overflow, out_underflow, out_inexact;
  logic [31:0] out_result;
  int          checks = 0, failures = 0;
  logic [34:0] sb[$];
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out = 35'd0;
  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [47:0] p;
    logic [2:0]  zin;
    logic [34:0] x;
  } vec_t;
  vec_t tv[16];
  always #5 clk = ~clk;
  fp_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_prod(in_prod), .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );
  function automatic logic [34:0] dut_out();
    return {out_result, out_overflow, out_underflow, out_inexact};
  endfunction
  // Value-level reference: integer quotient/remainder rounding rather than guard/sticky bits
  function automatic logic [34:0] model(logic s, logic [9:0] e, logic [47:0] p, logic z, logic i, logic n);
    longint unsigned prod, q, rem, half;
    int sh, ex;
    logic up;
    if (n || (i && z)) return {32'h7FC00000, 3'b000};
    if (i) return {s, 8'hFF, 23'd0, 3'b000};
    if (z) return {s, 31'd0, 3'b000};
    prod = 64'(p);
    sh = p[47] ? 24 : 23;
    ex = int'($signed(e)) + (p[47] ? 1 : 0);
    q = prod >> sh;
    rem = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    up = (rem > half) || (rem == half && q[0]);
    q = q + 64'(up);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    if (ex <= 0) return {s, 31'd0, 3'b011};
    return {s, 8'(ex), 23'(q), 2'b00, rem != 0};
  endfunction
  function automatic vec_t v(logic s, logic [9:0] e, logic [47:0] p, logic [2:0] zin, logic [31:0] r, logic [2:0] f);
    vec_t t;
    t.s = s; t.e = e; t.p = p; t.zin = zin; t.x = {r, f};
    return t;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic rand_in();
    logic [23:0] a, b;
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    if ($urandom % 4 == 0) a[15:0] = 16'd0;
    if ($urandom % 4 == 0) b[15:0] = 16'd0;
    in_prod = 48'(a) * 48'(b);
    in_exp  = 10'($urandom_range(0, 510)) - 10'd127;
    in_sign = 1'($urandom);
    in_zero = ($urandom % 10 == 0);
    in_inf  = ($urandom % 12 == 0);
    in_nan  = ($urandom % 15 == 0);
  endtask
  task automatic drain(string name);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("stall_hold", 64'({out_valid, dut_out()}), 64'({1'b1, prev_out}));
      prev_stall = out_valid && !out_ready;
      prev_out = dut_out();
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra actual=%h required=no_output", dut_out());
        end else chk("sb_result", 64'(dut_out()), 64'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(model(in_sign, in_exp, in_prod, in_zero, in_inf, in_nan));
    end
  end
  initial begin
    int k, seen;
    logic acc, done;
    tv[0]  = v(1'b0, 10'd127, 48'h400000000000, 3'b000, 32'h3F800000, 3'b000);
    tv[1]  = v(1'b0, 10'd127, 48'h900000000000, 3'b000, 32'h40100000, 3'b000);
    tv[2]  = v(1'b0, 10'd127, 48'h400000C00000, 3'b000, 32'h3F800002, 3'b001);
    tv[3]  = v(1'b0, 10'd127, 48'h400000400000, 3'b000, 32'h3F800000, 3'b001);
    tv[4]  = v(1'b0, 10'd127, 48'h7FFFFFC00000, 3'b000, 32'h40000000, 3'b001);
    tv[5]  = v(1'b0, 10'd254, 48'h800000000000, 3'b000, 32'h7F800000, 3'b101);
    tv[6]  = v(1'b1, 10'd0,   48'h400000000000, 3'b000, 32'h80000000, 3'b011);
    tv[7]  = v(1'b0, 10'd127, 48'h400000000000, 3'b110, 32'h7FC00000, 3'b000);
    tv[8]  = v(1'b1, 10'd127, 48'h400000000000, 3'b001, 32'h7FC00000, 3'b000);
    tv[9]  = v(1'b1, 10'd127, 48'h400000000000, 3'b010, 32'hFF800000, 3'b000);
    tv[10] = v(1'b1, 10'd127, 48'h000000000000, 3'b100, 32'h80000000, 3'b000);
    tv[11] = v(1'b0, 10'd253, 48'h800000000000, 3'b000, 32'h7F000000, 3'b000);
    tv[12] = v(1'b0, 10'd1,   48'h400000000000, 3'b000, 32'h00800000, 3'b000);
    tv[13] = v(1'b0, 10'h381, 48'h800000000000, 3'b000, 32'h00000000, 3'b011);
    tv[14] = v(1'b0, 10'd254, 48'h7FFFFFC00000, 3'b000, 32'h7F800000, 3'b101);
    tv[15] = v(1'b1, 10'h17F, 48'h800000000000, 3'b000, 32'hFF800000, 3'b101);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst_out", 64'({out_valid, dut_out()}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    foreach (tv[i]) begin
      @(posedge clk); #1;
      in_sign = tv[i].s; in_exp = tv[i].e; in_prod = tv[i].p;
      {in_zero, in_inf, in_nan} = tv[i].zin;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_early", i), 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 64'({out_valid, dut_out()}), 64'({1'b1, tv[i].x}));
    end
    drain("drain_table");
    @(posedge clk); #1;
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      rand_in();
      in_valid = 1'b1;
      #1 acc = in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    chk("bp_accepts", 64'(k), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && k < 6; c++) begin
      rand_in();
      in_valid = 1'b1;
      #1 acc = in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_total", 64'(k), 64'd6);
    drain("drain_bp");
    done = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        rand_in();
        in_valid = ($urandom % 4 != 0);
      end
      out_ready = ($urandom % 3 != 0);
      #1 done = !in_valid || in_ready;
      @(posedge clk); #1;
    end
    drain("drain_rand");
    @(posedge clk); #1;
    out_ready = 1'b0;
    rand_in();
    in_valid = 1'b1;
    @(posedge clk); #1;
    rand_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_before_rst", 64'({out_valid, in_ready}), 64'h2);
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'({out_valid, dut_out()}), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_no_stale", 64'(seen), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
